// File: rtl/nv_ram_rwsp_fifo_ctl.sv
// Controller for a FIFO that uses an external 2-port RAM with registered read.
// The RAM latches its read address on ram_re and loads its output register on
// ram_ore. Data therefore reaches rd_pd two edges after the address is issued.
// The write side accepts a word whenever the RAM has a free slot. The read side
// keeps the two-stage read pipeline full, so it can sustain one word per cycle.
// A RAM slot stays allocated until its data has been captured into the RAM
// output register. Total buffering is therefore DEPTH words in the RAM plus one
// word in the output register.
module nv_ram_rwsp_fifo_ctl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 129
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   fifo_cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Each pointer carries an extra wrap bit. The difference of the two pointers
  // is then unambiguous over the range 0..DEPTH.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] avail;
  logic [AW:0] occ;
  logic        s1_vld;   // a read address is latched in the RAM, data not yet captured

  // Write side. There is no bypass when the FIFO is full: a slot that is freed
  // by ram_ore becomes writable only in the following cycle.
  assign wr_prdy = (occ != FULL_CNT);
  // The write enable is gated by reset. This prevents a stray RAM write while
  // the controller is held in reset.
  assign ram_we  = wr_pvld & wr_prdy & nvdla_core_rstn;
  assign ram_wa  = wr_ptr[AW-1:0];
  assign ram_di  = wr_pd;

  // Read pipeline. avail counts only completed writes. A read therefore never
  // targets the address that is being written at the same edge.
  assign avail   = wr_ptr - rd_ptr;
  assign ram_ore = s1_vld & (~rd_pvld | rd_prdy);
  // A new address is issued only when stage 1 is empty or is moving forward.
  // The latched address therefore stays stable during a stall.
  assign ram_re  = (avail != '0) & (~s1_vld | ram_ore);
  assign ram_ra  = rd_ptr[AW-1:0];

  // The RAM output register holds its value while ore is low. It can therefore
  // drive the payload directly.
  assign rd_pd    = ram_dout;
  assign fifo_cnt = occ;

  // Pointer advance on write and on read-address issue.
  // NOTE: all state uses non-blocking assignment, so every flop samples the
  // values from before the edge and the order of statements does not matter.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (ram_re) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Valid bits for the two read stages: address latched, then output registered.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld  <= 1'b0;
      rd_pvld <= 1'b0;
    end else begin
      s1_vld  <= ram_re  | (s1_vld  & ~ram_ore);
      rd_pvld <= ram_ore | (rd_pvld & ~rd_prdy);
    end
  end

  // RAM occupancy: a slot is allocated by a write and freed by capture into the output register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      occ <= '0;
    end else begin
      case ({ram_we, ram_ore})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_nv_ram_rwsp_fifo_ctl.sv
// Self-checking bench for nv_ram_rwsp_fifo_ctl. It includes a behavioural model
// of the register-read RAM, a cycle-by-cycle vector table, directed corner
// sequences, and a scoreboard that receives a randomized stream.
module tb_nv_ram_rwsp_fifo_ctl;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 129;

  logic          clk;
  logic          rstn;
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic [AW-1:0] ram_wa;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic          ram_ore;
  logic [DW-1:0] ram_dout;
  logic [AW:0]   fifo_cnt;

  nv_ram_rwsp_fifo_ctl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .wr_pvld        (wr_pvld),
    .wr_prdy        (wr_prdy),
    .wr_pd          (wr_pd),
    .rd_pvld        (rd_pvld),
    .rd_prdy        (rd_prdy),
    .rd_pd          (rd_pd),
    .ram_wa         (ram_wa),
    .ram_we         (ram_we),
    .ram_di         (ram_di),
    .ram_ra         (ram_ra),
    .ram_re         (ram_re),
    .ram_ore        (ram_ore),
    .ram_dout       (ram_dout),
    .fifo_cnt       (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: write port, read-address latch, output register.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_q;
  logic [DW-1:0] dout_q;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_q        <= ram_ra;
    if (ram_ore) dout_q      <= mem[ra_q];
  end
  assign ram_dout = dout_q;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model of the FIFO as a whole. It tracks words in order, counts
  // words inside the block, computes expected RAM addresses, and counts reads
  // that have been issued but not yet captured.
  logic [DW-1:0] q[$];
  int            in_sys;
  logic [AW-1:0] wa_exp;
  logic [AW-1:0] ra_exp;
  int            pending;

  task automatic model_reset();
    q.delete();
    in_sys  = 0;
    wa_exp  = '0;
    ra_exp  = '0;
    pending = 0;
  endtask

  // Checks and model update for the current cycle, sampled before the active edge.
  task automatic mon();
    logic [DW-1:0] e;
    int occ_m;
    occ_m = in_sys - int'(rd_pvld);
    check("fifo_cnt", fifo_cnt, occ_m);
    check("cnt_le_depth", fifo_cnt <= DEPTH, 1'b1);
    check("wr_prdy", wr_prdy, occ_m != DEPTH);
    check("ram_we", ram_we, wr_pvld & wr_prdy);
    if (ram_we) begin
      check("ram_wa", ram_wa, wa_exp);
      check("ram_di", ram_di, wr_pd);
      q.push_back(wr_pd);
      wa_exp = wa_exp + 1'b1;
    end
    check("re_during_stall", pending == 1 && !ram_ore && ram_re, 1'b0);
    check("ore_without_read", ram_ore && pending == 0, 1'b0);
    if (ram_re) begin
      check("ram_ra", ram_ra, ra_exp);
      ra_exp = ra_exp + 1'b1;
    end
    pending = pending + int'(ram_re) - int'(ram_ore);
    if (ram_we) in_sys++;
    if (rd_pvld && rd_prdy) begin
      if (q.size() == 0) begin
        check("rd_unexpected", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        check("rd_pd", rd_pd, e);
      end
      in_sys--;
    end
  endtask

  task automatic cycle(input logic wv, input logic [DW-1:0] pd, input logic rp);
    @(negedge clk);
    wr_pvld = wv;
    wr_pd   = pd;
    rd_prdy = rp;
    #1;
    mon();
    cyc++;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  typedef struct {
    logic          wv;
    logic          rp;
    logic [DW-1:0] pd;
    logic          e_prdy;
    logic          e_we;
    logic          e_re;
    logic          e_ore;
    logic          e_pvld;
    logic [AW:0]   e_cnt;
    logic          chk_pd;
    logic [DW-1:0] e_pd;
  } vec_t;

  function automatic vec_t mk(logic wv, logic rp, logic [DW-1:0] pd, logic prdy, logic we,
                              logic re, logic ore, logic pvld, int cnt, logic cp,
                              logic [DW-1:0] epd);
    vec_t v;
    v.wv = wv; v.rp = rp; v.pd = pd;
    v.e_prdy = prdy; v.e_we = we; v.e_re = re; v.e_ore = ore; v.e_pvld = pvld;
    v.e_cnt = (AW+1)'(cnt); v.chk_pd = cp; v.e_pd = epd;
    return v;
  endfunction

  // Watchdog: the run must always reach its summary line.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs [12];
    logic [DW-1:0] wa, wb, wc, d, w0, first_word;
    int            acc, got, gaps, first_pv, lat;
    logic          seen, found;

    wa = {1'b1, 128'hAB};
    wb = 129'h0BEEF;
    wc = {1'b1, 128'hCAFE_F00D};
    //           wv rp pd  | prdy we re ore pvld cnt | chk pd
    vecs[0]  = mk(1, 1, wa,   1, 1, 0, 0, 0, 0,   0, '0);
    vecs[1]  = mk(0, 1, '0,   1, 0, 1, 0, 0, 1,   0, '0);
    vecs[2]  = mk(0, 1, '0,   1, 0, 0, 1, 0, 1,   0, '0);
    vecs[3]  = mk(0, 1, '0,   1, 0, 0, 0, 1, 0,   1, wa);
    vecs[4]  = mk(0, 1, '0,   1, 0, 0, 0, 0, 0,   0, '0);
    vecs[5]  = mk(1, 0, wb,   1, 1, 0, 0, 0, 0,   0, '0);
    vecs[6]  = mk(1, 0, wc,   1, 1, 1, 0, 0, 1,   0, '0);
    vecs[7]  = mk(0, 0, '0,   1, 0, 1, 1, 0, 2,   0, '0);
    vecs[8]  = mk(0, 0, '0,   1, 0, 0, 0, 1, 1,   1, wb);
    vecs[9]  = mk(0, 1, '0,   1, 0, 0, 1, 1, 1,   1, wb);
    vecs[10] = mk(0, 1, '0,   1, 0, 0, 0, 1, 0,   1, wc);
    vecs[11] = mk(0, 1, '0,   1, 0, 0, 0, 0, 0,   0, '0);

    // Reset state.
    rstn = 1'b0; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    model_reset();
    #1;
    check("rst_rd_pvld", rd_pvld, 1'b0);
    check("rst_fifo_cnt", fifo_cnt, 0);
    check("rst_wr_prdy", wr_prdy, 1'b1);
    check("rst_ram_re", ram_re, 1'b0);
    check("rst_ram_ore", ram_ore, 1'b0);
    #20;
    @(negedge clk) rstn = 1'b1;

    // Table: single-word latency followed by a short stall-and-release sequence.
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].wv, vecs[i].pd, vecs[i].rp);
      check($sformatf("vec%0d_wr_prdy", i), wr_prdy, vecs[i].e_prdy);
      check($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].e_we);
      check($sformatf("vec%0d_ram_re", i), ram_re, vecs[i].e_re);
      check($sformatf("vec%0d_ram_ore", i), ram_ore, vecs[i].e_ore);
      check($sformatf("vec%0d_rd_pvld", i), rd_pvld, vecs[i].e_pvld);
      check($sformatf("vec%0d_fifo_cnt", i), fifo_cnt, vecs[i].e_cnt);
      if (vecs[i].chk_pd) check($sformatf("vec%0d_rd_pd", i), rd_pd, vecs[i].e_pd);
    end

    // Streaming: 200 incrementing words with rd_prdy held high, across pointer wraps.
    got = 0; gaps = 0; first_pv = -1; seen = 1'b0;
    for (int i = 0; i < 220; i++) begin
      cycle(i < 200, 129'(i + 1000), 1'b1);
      if (rd_pvld) begin
        if (!seen) first_pv = i;
        seen = 1'b1;
        got++;
      end else if (seen && got < 200) begin
        gaps++;
      end
    end
    check("stream_first_latency", first_pv, 3);
    check("stream_count", got, 200);
    check("stream_gaps", gaps, 0);
    check("stream_drained", q.size(), 0);

    // Fill while rd_prdy is low: expect 65 accepts and then backpressure.
    acc = 0;
    first_word = 129'h5000;
    d = first_word;
    for (int i = 0; i < 72; i++) begin
      cycle(1'b1, d, 1'b0);
      if (wr_prdy) begin acc++; d = d + 1'b1; end
    end
    check("full_accepts", acc, 65);
    check("full_fifo_cnt", fifo_cnt, DEPTH);
    check("full_wr_prdy", wr_prdy, 1'b0);
    check("full_rd_pvld", rd_pvld, 1'b1);
    check("full_rd_pd", rd_pd, first_word);
    // Release reads with the write still pending: no write bypass in the ore cycle.
    cycle(1'b1, d, 1'b1);
    check("release_ore", ram_ore, 1'b1);
    check("release_no_we", ram_we, 1'b0);
    cycle(1'b1, d, 1'b1);
    check("release_next_wr_prdy", wr_prdy, 1'b1);
    check("release_next_we", ram_we, 1'b1);
    for (int i = 0; i < 200 && q.size() != 0; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("full_drained", q.size(), 0);

    // Random backpressure with continuous writes, 1000 words.
    acc = 0;
    d = rand_word();
    for (int i = 0; i < 6000 && acc < 1000; i++) begin
      cycle(1'b1, d, 1'($urandom_range(0, 1)));
      if (wr_prdy) begin acc++; d = rand_word(); end
    end
    check("rand_accepts", acc, 1000);
    for (int i = 0; i < 300 && q.size() != 0; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("rand_drained", q.size(), 0);
    check("rand_idle_cnt", fifo_cnt, 0);

    // Asynchronous reset with 10 words in flight.
    for (int i = 0; i < 10; i++) cycle(1'b1, 129'(i + 77), 1'b0);
    cycle(1'b1, 129'h99, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rd_pvld", rd_pvld, 1'b0);
    check("async_fifo_cnt", fifo_cnt, 0);
    check("async_wr_prdy", wr_prdy, 1'b1);
    check("async_ram_we", ram_we, 1'b0);
    check("async_ram_re", ram_re, 1'b0);
    check("async_ram_ore", ram_ore, 1'b0);
    model_reset();
    @(negedge clk) wr_pvld = 1'b0;
    @(negedge clk) rstn = 1'b1;
    w0 = {1'b1, 128'h1234_5678};
    cycle(1'b1, w0, 1'b1);
    check("post_reset_wa", ram_wa, 0);
    lat = 0; found = 1'b0;
    for (int i = 1; i <= 8 && !found; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (rd_pvld) begin
        found = 1'b1;
        lat = i;
        check("post_reset_rd_pd", rd_pd, w0);
      end
    end
    check("post_reset_seen", found, 1'b1);
    check("post_reset_latency", lat, 3);
    cycle(1'b0, '0, 1'b1);
    check("post_reset_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
